// File: rtl/c_fetch_align_ctrl.sv
// Fetch aligner: 32-bit I-cache words -> halfword ring -> one 16/32-bit instruction per valid&&ready.
// Fetch-to-decode latency 1 cycle (0 with ALIGN_BYPASS_EN); a nearly full ring stops requests, decode stall holds outputs.
module c_fetch_align_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  output logic        misaligned_o
);

  localparam int PW = $clog2(BUF_HW);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fstate_t;

  logic [15:0]   buf_q [BUF_HW];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d, avail;
  logic [31:0]   fetch_addr_q, req_addr_q, req_addr_d, pc_q;
  logic          skip_lo_q;
  fstate_t       state_q, state_d;

  logic          resp_take, bypass, accept, out_comp;
  logic [15:0]   out_hw0, out_hw1, push_hw0, push_hw1;
  logic [1:0]    push_n, pop_n, inst_len;

  assign resp_take = (state_q == F_WAIT) && icache_valid_i && !branch_taken_i;

`ifdef ALIGN_BYPASS_EN
  assign bypass = resp_take && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // Head of the ring, or the live response word when bypassing an empty ring
  always_comb begin
    out_hw0 = buf_q[rd_q];
    out_hw1 = buf_q[rd_q + PW'(1)];
    avail   = count_q;
    if (bypass) begin
      out_hw0 = skip_lo_q ? icache_data_i[31:16] : icache_data_i[15:0];
      out_hw1 = icache_data_i[31:16];
      avail   = skip_lo_q ? CW'(1) : CW'(2);
    end
    out_comp        = (out_hw0[1:0] != 2'b11);
    inst_len        = out_comp ? 2'd1 : 2'd2;
    inst_valid_o    = out_comp ? (avail >= CW'(1)) : (avail >= CW'(2));
    accept          = inst_valid_o && inst_ready_i && !branch_taken_i;
    inst_o          = 32'h0000_0013;
    if (inst_valid_o)
      inst_o = out_comp ? {16'h0000, out_hw0} : {out_hw1, out_hw0};
    is_compressed_o = inst_valid_o && out_comp;
    misaligned_o    = inst_valid_o && !out_comp && pc_q[1];
  end

  always_comb begin
    push_n   = 2'd0;
    push_hw0 = icache_data_i[15:0];
    push_hw1 = icache_data_i[31:16];
    if (resp_take) begin
      if (skip_lo_q) begin
        push_n   = 2'd1;
        push_hw0 = icache_data_i[31:16];
      end else begin
        push_n = 2'd2;
      end
    end
    pop_n = accept ? inst_len : 2'd0;
    // Bypassed halfwords consumed this cycle never enter the ring
    if (bypass && accept) begin
      push_n = push_n - inst_len;
      pop_n  = 2'd0;
      if (!skip_lo_q) push_hw0 = icache_data_i[31:16];
    end
    count_d = count_q + CW'(push_n) - CW'(pop_n);
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      F_IDLE: begin
        if (!branch_taken_i && (count_q <= CW'(BUF_HW - 2))) begin
          state_d    = F_WAIT;
          req_addr_d = fetch_addr_q;
        end
      end
      F_WAIT: begin
        if (branch_taken_i) begin
          state_d = icache_valid_i ? F_IDLE : F_DROP;
        end else if (icache_valid_i) begin
          if (count_d <= CW'(BUF_HW - 4)) req_addr_d = fetch_addr_q + 32'd4;
          else                            state_d    = F_IDLE;
        end
      end
      F_DROP: begin
        if (icache_valid_i) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign icache_req_o  = (state_q != F_IDLE);
  assign icache_addr_o = req_addr_q;
  assign pc_o          = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= F_IDLE;
      req_addr_q   <= {RESET_PC[31:2], 2'b00};
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      skip_lo_q    <= RESET_PC[1];
      pc_q         <= RESET_PC;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      if (branch_taken_i) begin
        fetch_addr_q <= branch_target_i & 32'hFFFF_FFFC;
        skip_lo_q    <= branch_target_i[1];
        pc_q         <= branch_target_i & 32'hFFFF_FFFE;
        rd_q         <= '0;
        wr_q         <= '0;
        count_q      <= '0;
      end else begin
        wr_q    <= wr_q + PW'(push_n);
        rd_q    <= rd_q + PW'(pop_n);
        count_q <= count_d;
        if (accept) pc_q <= pc_q + {29'd0, inst_len, 1'b0};
        if (resp_take) begin
          fetch_addr_q <= fetch_addr_q + 32'd4;
          skip_lo_q    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !branch_taken_i) begin
      if (push_n != 2'd0) buf_q[wr_q]          <= push_hw0;
      if (push_n == 2'd2) buf_q[wr_q + PW'(1)] <= push_hw1;
    end
  end

endmodule

// File: tb/tb_c_fetch_align_ctrl.sv
// Directed bench for c_fetch_align_ctrl: I-cache responder with configurable latency plus a decode-side transfer monitor.
module tb_c_fetch_align_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_valid_i;
  logic [31:0] icache_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        is_compressed_o;
  logic        misaligned_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [128];
  bit          resp_en = 1'b0;
  int          lat = 0;
  int          pend = 0;
  logic        auto_vld = 1'b0;
  logic [31:0] auto_dat = 32'h0;
  logic        man_vld = 1'b0;
  logic [31:0] man_dat = 32'h0;

  logic [31:0] req_log [$];
  logic [31:0] rec_pc [$];
  logic [31:0] rec_inst [$];
  logic        rec_comp [$];
  logic        rec_mis [$];
  int          rec_cyc [$];
  int          cyc = 0;
  int          rec_base = 0;
  int          log_base = 0;

  assign icache_valid_i = resp_en ? auto_vld : man_vld;
  assign icache_data_i  = resp_en ? auto_dat : man_dat;

  always #5 clk = ~clk;

  c_fetch_align_ctrl #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .icache_req_o    (icache_req_o),
    .icache_addr_o   (icache_addr_o),
    .icache_valid_i  (icache_valid_i),
    .icache_data_i   (icache_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .is_compressed_o (is_compressed_o),
    .misaligned_o    (misaligned_o)
  );

  // I-cache model: answers `lat` cycles after it first sees a request
  initial begin
    forever begin
      @(posedge clk);
      #2;
      auto_vld = 1'b0;
      if (resp_en && icache_req_o && !reset) begin
        if (pend >= lat) begin
          auto_vld = 1'b1;
          auto_dat = mem[icache_addr_o[8:2]];
          req_log.push_back(icache_addr_o);
          pend = 0;
        end else begin
          pend++;
        end
      end else begin
        pend = 0;
      end
    end
  end

  // Decode-side monitor; a redirect-cycle accept is not a real transfer
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && !branch_taken_i && inst_valid_o && inst_ready_i) begin
        rec_pc.push_back(pc_o);
        rec_inst.push_back(inst_o);
        rec_comp.push_back(is_compressed_o);
        rec_mis.push_back(misaligned_o);
        rec_cyc.push_back(cyc);
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0001_0001;
  endtask

  task automatic do_reset();
    reset = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0; man_vld = 1'b0; man_dat = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    rec_base = rec_pc.size();
    log_base = req_log.size();
  endtask

  task automatic wait_recs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (rec_pc.size() - rec_base >= n) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    fill_mem();
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b0;
    reset = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", icache_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o); end
    checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL rst_inst got=%h exp=00000013", inst_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=00000000", pc_o); end
    checks++; if (is_compressed_o !== 1'b0) begin errors++; $display("FAIL rst_comp got=%b exp=0", is_compressed_o); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL rst_mis got=%b exp=0", misaligned_o); end
    @(posedge clk); #1;
    reset = 1'b0; rec_base = rec_pc.size(); log_base = req_log.size();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icache_valid_i) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_first_resp got=none exp=response within 20 cycles"); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL lat_resp_cycle valid got=%b exp=0", inst_valid_o); end
    checks++; if (req_log.size() <= log_base || req_log[log_base] !== 32'h0) begin errors++; $display("FAIL rst_first_addr got=%0d entries exp addr 0", req_log.size() - log_base); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL lat_next_cycle valid got=%b exp=1", inst_valid_o); end
    checks++; if (inst_o !== 32'h0000_0001) begin errors++; $display("FAIL lat_inst got=%h exp=00000001", inst_o); end
    checks++; if (is_compressed_o !== 1'b1) begin errors++; $display("FAIL lat_comp got=%b exp=1", is_compressed_o); end
  endtask

  task automatic test_aligned32();
    bit ok;
    fill_mem(); mem[0] = 32'h0013_0013; mem[1] = 32'h0013_0013;
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b1;
    do_reset();
    wait_recs(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL a32_timeout got=%0d recs exp=2", rec_pc.size() - rec_base); end
    if (ok) begin
      checks++; if (rec_pc[rec_base] !== 32'h0) begin errors++; $display("FAIL a32_pc0 got=%h exp=0", rec_pc[rec_base]); end
      checks++; if (rec_inst[rec_base] !== 32'h0013_0013) begin errors++; $display("FAIL a32_inst0 got=%h exp=00130013", rec_inst[rec_base]); end
      checks++; if (rec_comp[rec_base] !== 1'b0) begin errors++; $display("FAIL a32_comp0 got=%b exp=0", rec_comp[rec_base]); end
      checks++; if (rec_mis[rec_base] !== 1'b0) begin errors++; $display("FAIL a32_mis0 got=%b exp=0", rec_mis[rec_base]); end
      checks++; if (rec_pc[rec_base+1] !== 32'h4) begin errors++; $display("FAIL a32_pc1 got=%h exp=4", rec_pc[rec_base+1]); end
      checks++; if (rec_inst[rec_base+1] !== 32'h0013_0013) begin errors++; $display("FAIL a32_inst1 got=%h exp=00130013", rec_inst[rec_base+1]); end
    end
  endtask

  task automatic test_compressed();
    bit ok;
    fill_mem(); mem[0] = 32'h4501_0001;
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b1;
    do_reset();
    wait_recs(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rvc_timeout got=%0d recs exp=3", rec_pc.size() - rec_base); end
    if (ok) begin
      checks++; if (rec_pc[rec_base] !== 32'h0 || rec_inst[rec_base] !== 32'h1) begin errors++; $display("FAIL rvc_0 got pc=%h inst=%h exp pc=0 inst=1", rec_pc[rec_base], rec_inst[rec_base]); end
      checks++; if (rec_comp[rec_base] !== 1'b1) begin errors++; $display("FAIL rvc_comp0 got=%b exp=1", rec_comp[rec_base]); end
      checks++; if (rec_pc[rec_base+1] !== 32'h2 || rec_inst[rec_base+1] !== 32'h4501) begin errors++; $display("FAIL rvc_1 got pc=%h inst=%h exp pc=2 inst=4501", rec_pc[rec_base+1], rec_inst[rec_base+1]); end
      checks++; if (rec_comp[rec_base+1] !== 1'b1) begin errors++; $display("FAIL rvc_comp1 got=%b exp=1", rec_comp[rec_base+1]); end
      checks++; if (rec_pc[rec_base+2] !== 32'h4 || rec_inst[rec_base+2] !== 32'h1) begin errors++; $display("FAIL rvc_2 got pc=%h inst=%h exp pc=4 inst=1", rec_pc[rec_base+2], rec_inst[rec_base+2]); end
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    fill_mem(); mem[0] = 32'h0513_0001; mem[1] = 32'h0001_0000;
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    #1; inst_ready_i = 1'b1;
    wait_recs(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_timeout got=%0d recs exp=3", rec_pc.size() - rec_base); end
    if (ok) begin
      checks++; if (rec_pc[rec_base] !== 32'h0 || rec_inst[rec_base] !== 32'h1) begin errors++; $display("FAIL mis_0 got pc=%h inst=%h exp pc=0 inst=1", rec_pc[rec_base], rec_inst[rec_base]); end
      checks++; if (rec_pc[rec_base+1] !== 32'h2) begin errors++; $display("FAIL mis_pc1 got=%h exp=2", rec_pc[rec_base+1]); end
      checks++; if (rec_inst[rec_base+1] !== 32'h0000_0513) begin errors++; $display("FAIL mis_inst1 got=%h exp=00000513", rec_inst[rec_base+1]); end
      checks++; if (rec_mis[rec_base+1] !== 1'b1 || rec_comp[rec_base+1] !== 1'b0) begin errors++; $display("FAIL mis_flags1 got mis=%b comp=%b exp mis=1 comp=0", rec_mis[rec_base+1], rec_comp[rec_base+1]); end
      checks++; if (rec_pc[rec_base+2] !== 32'h6 || rec_inst[rec_base+2] !== 32'h1 || rec_mis[rec_base+2] !== 1'b0) begin errors++; $display("FAIL mis_2 got pc=%h inst=%h mis=%b exp pc=6 inst=1 mis=0", rec_pc[rec_base+2], rec_inst[rec_base+2], rec_mis[rec_base+2]); end
      checks++; if (rec_cyc[rec_base+1] !== rec_cyc[rec_base] + 1) begin errors++; $display("FAIL mis_bubble01 got gap=%0d exp=1", rec_cyc[rec_base+1] - rec_cyc[rec_base]); end
      checks++; if (rec_cyc[rec_base+2] !== rec_cyc[rec_base+1] + 1) begin errors++; $display("FAIL mis_bubble12 got gap=%0d exp=1", rec_cyc[rec_base+2] - rec_cyc[rec_base+1]); end
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    fill_mem(); mem[0] = 32'hDEAD_BEEF; mem[65] = 32'h4501_0513;
    resp_en = 1'b1; lat = 3; inst_ready_i = 1'b1;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icache_req_o) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rdw_req got req=0 exp req=1 within 20 cycles"); end
    @(posedge clk); #1;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0107;
    @(posedge clk); #1;
    branch_taken_i = 1'b0; branch_target_i = 32'h0;
    @(negedge clk);
    checks++; if (icache_req_o !== 1'b1 || icache_addr_o !== 32'h0) begin errors++; $display("FAIL rdw_drop_req got req=%b addr=%h exp req=1 addr=0", icache_req_o, icache_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_drop_valid got=%b exp=0", inst_valid_o); end
    wait_recs(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdw_timeout got=%0d recs exp=2", rec_pc.size() - rec_base); end
    checks++; if (req_log.size() < log_base + 2 || req_log[log_base+1] !== 32'h104) begin errors++; $display("FAIL rdw_new_addr got=%0d entries exp second addr 104", req_log.size() - log_base); end
    if (ok) begin
      checks++; if (rec_pc[rec_base] !== 32'h106) begin errors++; $display("FAIL rdw_pc0 got=%h exp=106", rec_pc[rec_base]); end
      checks++; if (rec_inst[rec_base] !== 32'h4501 || rec_comp[rec_base] !== 1'b1) begin errors++; $display("FAIL rdw_inst0 got=%h comp=%b exp=4501 comp=1", rec_inst[rec_base], rec_comp[rec_base]); end
      checks++; if (rec_pc[rec_base+1] !== 32'h108 || rec_inst[rec_base+1] !== 32'h1) begin errors++; $display("FAIL rdw_1 got pc=%h inst=%h exp pc=108 inst=1", rec_pc[rec_base+1], rec_inst[rec_base+1]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_pc [6];
    logic [31:0] exp_inst [6];
    exp_pc   = '{32'h0, 32'h4, 32'h6, 32'h8, 32'hA, 32'hE};
    exp_inst = '{32'h0013_0013, 32'h1, 32'h4501, 32'h1, 32'h0000_0513, 32'h1};
    fill_mem();
    mem[0] = 32'h0013_0013; mem[1] = 32'h4501_0001; mem[2] = 32'h0513_0001; mem[3] = 32'h0001_0000;
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0013_0013) begin errors++; $display("FAIL bp_hold_a got v=%b inst=%h exp v=1 inst=00130013", inst_valid_o, inst_o); end
    repeat (6) @(negedge clk);
    checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL bp_full_req got=%b exp=0", icache_req_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0013_0013) begin errors++; $display("FAIL bp_hold_b got v=%b inst=%h exp v=1 inst=00130013", inst_valid_o, inst_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL bp_pc got=%h exp=0", pc_o); end
    checks++; if (req_log.size() - log_base !== 2) begin errors++; $display("FAIL bp_fetches got=%0d exp=2", req_log.size() - log_base); end
    @(posedge clk); #1; inst_ready_i = 1'b1;
    wait_recs(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=%0d recs exp=6", rec_pc.size() - rec_base); end
    if (ok) begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (rec_pc[rec_base+k] !== exp_pc[k] || rec_inst[rec_base+k] !== exp_inst[k]) begin errors++; $display("FAIL bp_drain%0d got pc=%h inst=%h exp pc=%h inst=%h", k, rec_pc[rec_base+k], rec_inst[rec_base+k], exp_pc[k], exp_inst[k]); end
      end
      checks++; if (rec_mis[rec_base+4] !== 1'b1) begin errors++; $display("FAIL bp_wrap_mis got=%b exp=1", rec_mis[rec_base+4]); end
    end
  endtask

  task automatic test_branch_accept();
    bit ok;
    fill_mem(); mem[32] = 32'h0013_0013;
    resp_en = 1'b0; inst_ready_i = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icache_req_o) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ba_req0 got req=0 exp req=1 within 20 cycles"); end
    @(posedge clk); #1; man_vld = 1'b1; man_dat = 32'h0001_0001;
    @(posedge clk); #1; man_vld = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icache_req_o) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || icache_addr_o !== 32'h4) begin errors++; $display("FAIL ba_req1 got req=%b addr=%h exp req=1 addr=4", icache_req_o, icache_addr_o); end
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL ba_pre got v=%b pc=%h exp v=1 pc=0", inst_valid_o, pc_o); end
    @(posedge clk); #1;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0080;
    man_vld = 1'b1; man_dat = 32'h4501_4501; inst_ready_i = 1'b1;
    @(posedge clk); #1;
    branch_taken_i = 1'b0; branch_target_i = 32'h0; man_vld = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL ba_valid got=%b exp=0", inst_valid_o); end
    checks++; if (pc_o !== 32'h80) begin errors++; $display("FAIL ba_pc got=%h exp=80", pc_o); end
    checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL ba_inst got=%h exp=00000013", inst_o); end
    checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL ba_idle got req=%b exp=0", icache_req_o); end
    checks++; if (rec_pc.size() - rec_base !== 0) begin errors++; $display("FAIL ba_no_xfer got=%0d exp=0", rec_pc.size() - rec_base); end
    resp_en = 1'b1; lat = 0; inst_ready_i = 1'b1;
    wait_recs(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ba_timeout got=0 recs exp=1"); end
    checks++; if (req_log.size() <= log_base || req_log[log_base] !== 32'h80) begin errors++; $display("FAIL ba_addr got=%0d entries exp first addr 80", req_log.size() - log_base); end
    if (ok) begin
      checks++; if (rec_pc[rec_base] !== 32'h80 || rec_inst[rec_base] !== 32'h0013_0013) begin errors++; $display("FAIL ba_first got pc=%h inst=%h exp pc=80 inst=00130013", rec_pc[rec_base], rec_inst[rec_base]); end
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0; inst_ready_i = 1'b0;
    test_reset();
    test_aligned32();
    test_compressed();
    test_misaligned();
    test_redirect_wait();
    test_backpressure();
    test_branch_accept();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
